// File: rtl/sync_fifo_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param_pkg
//  Brief    : Shared defaults, error-flag bit positions and helpers for the
//             parametrised synchronous FIFO.
//  Revision : 1.0
// ============================================================================
package sync_fifo_param_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Bit positions inside the sticky error vector / status registers
    localparam int ERR_BITS          = 2;
    localparam int ERR_OVERFLOW_BIT  = 0;
    localparam int ERR_UNDERFLOW_BIT = 1;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram
//  Brief    : Simple dual-port synchronous RAM, one write port and one
//             registered read port. Contents and read register are not reset.
//  Revision : 1.0
// ============================================================================
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Read-before-write: a same-address read returns the old word
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Brief    : Parametrised single-clock FIFO with occupancy count,
//             almost-full/almost-empty flags and sticky error flags.
//  Revision : 1.0
// ============================================================================
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF    = c_CNT_W'(AF_THRESH);
    localparam logic [c_CNT_W-1:0] c_AE    = c_CNT_W'(AE_THRESH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two >= 4");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
            $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_empty;
    logic                r_full;
    logic                r_almost_empty;
    logic                r_almost_full;
    logic                r_data_valid;
    logic                r_has_data;
    logic [ERR_BITS-1:0] r_err;

    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [ERR_BITS-1:0] w_err_set;
    logic [WIDTH-1:0]    w_ram_q;

    // Gating with rst_n keeps X inputs during reset away from RAM and pointers
    assign w_rd_acc = rst_n & read_en & ~r_empty;
    assign w_wr_acc = rst_n & write_en & (~r_full | w_rd_acc);

    assign w_count_nxt = r_count + c_CNT_W'(w_wr_acc) - c_CNT_W'(w_rd_acc);

    always_comb begin
        w_err_set                    = '0;
        w_err_set[ERR_OVERFLOW_BIT]  = write_en & ~w_wr_acc;
        w_err_set[ERR_UNDERFLOW_BIT] = read_en & ~w_rd_acc;
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= (AF_THRESH == 0);
            r_data_valid   <= 1'b0;
            r_has_data     <= 1'b0;
            r_err          <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + c_ADDR_W'(1);
                r_has_data <= 1'b1;
            end
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == c_DEPTH);
            r_almost_empty <= (w_count_nxt <= c_AE);
            r_almost_full  <= (w_count_nxt >= c_AF);
            r_data_valid   <= w_rd_acc;
            // A fresh error in the same cycle as clr_err wins
            r_err          <= (r_err & ~{ERR_BITS{clr_err}}) | w_err_set;
        end
    end

    // The RAM read register has no reset; present zero until the first read
    assign data_out     = r_has_data ? w_ram_q : '0;
    assign data_valid   = r_data_valid;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_err[ERR_OVERFLOW_BIT];
    assign underflow    = r_err[ERR_UNDERFLOW_BIT];

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Brief    : Self-checking bench for sync_fifo_param with a queue model.
//  Revision : 1.0
// ============================================================================
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             write_en = 1'b0;
    logic             read_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid, empty, full, almost_empty, almost_full;
    logic [4:0]       count;
    logic             overflow, underflow;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_in      (data_in),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the FIFO contents as a plain queue
    logic [WIDTH-1:0] q[$];
    logic             m_ov = 1'b0, m_uf = 1'b0, m_dv = 1'b0;
    logic [WIDTH-1:0] m_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic re,
                        input logic ce, input logic [WIDTH-1:0] d);
        bit rd, wr;
        int sz;
        rst_n = r; write_en = we; read_en = re; clr_err = ce; data_in = d;
        @(posedge clk);
        if (r !== 1'b1) begin
            q.delete();
            m_ov = 1'b0; m_uf = 1'b0; m_dv = 1'b0; m_dout = '0;
        end else begin
            rd = (re === 1'b1) && (q.size() > 0);
            wr = (we === 1'b1) && ((q.size() < DEPTH) || rd);
            m_dv = rd;
            if (rd) m_dout = q.pop_front();
            if (wr) q.push_back(d);
            m_ov = (m_ov && !ce) || (we && !wr);
            m_uf = (m_uf && !ce) || (re && !rd);
        end
        #1;
        sz = q.size();
        check("count",        32'(count),   sz);
        check("empty",        empty,        sz == 0);
        check("full",         full,         sz == DEPTH);
        check("almost_empty", almost_empty, sz <= AE);
        check("almost_full",  almost_full,  sz >= AF);
        check("data_valid",   data_valid,   m_dv);
        check("data_out",     data_out,     m_dout);
        check("overflow",     overflow,     m_ov);
        check("underflow",    underflow,    m_uf);
    endtask

    typedef struct {
        logic             rst_n, we, re, clr;
        logic [WIDTH-1:0] din;
        int               exp_count;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_dv, exp_ov, exp_uf;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [WIDTH-1:0] rnd;

        // rst we re clr din | count dout dv ov uf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 2, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 2, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h77, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h77, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1, 8'h77, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h11, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst_n, vecs[i].we, vecs[i].re, vecs[i].clr, vecs[i].din);
            check($sformatf("vec%0d.count", i), 32'(count), vecs[i].exp_count);
            check($sformatf("vec%0d.dout", i),  data_out,   vecs[i].exp_dout);
            check($sformatf("vec%0d.dv", i),    data_valid, vecs[i].exp_dv);
            check($sformatf("vec%0d.ov", i),    overflow,   vecs[i].exp_ov);
            check($sformatf("vec%0d.uf", i),    underflow,  vecs[i].exp_uf);
        end

        // Fill 0x01..0x10 from a clean reset
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rst.empty", empty, 1'b1);
        check("rst.ae",    almost_empty, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, WIDTH'(i));
            if (i == 2)  check("fill2.ae",  almost_empty, 1'b1);
            if (i == 3)  check("fill3.ae",  almost_empty, 1'b0);
            if (i == 13) check("fill13.af", almost_full,  1'b0);
            if (i == 14) check("fill14.af", almost_full,  1'b1);
        end
        check("fill16.full",  full, 1'b1);
        check("fill16.count", 32'(count), 16);

        // 17th write is rejected
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        check("ovf.flag",  overflow, 1'b1);
        check("ovf.count", 32'(count), 16);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("ovf.first", data_out, 8'h01);
        check("ovf.dv",    data_valid, 1'b1);

        // Refill, then simultaneous read+write while full
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        check("refill.full", full, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
        check("fullrw.count", 32'(count), 16);
        check("fullrw.dout",  data_out, 8'h02);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, '0);
            check("drain.seq", data_out, WIDTH'(i + 3));
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("fullrw.aa",    data_out, 8'hAA);
        check("drain.empty",  empty, 1'b1);

        // Read on empty, then clear
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("udf.flag", underflow, 1'b1);
        check("udf.ovf",  overflow, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        check("clr.ovf", overflow, 1'b0);
        check("clr.udf", underflow, 1'b0);

        // Wrap-around at half occupancy
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, WIDTH'($urandom));
        for (int i = 0; i < 40; i++) begin
            rnd = WIDTH'($urandom);
            step(1'b1, 1'b1, 1'b1, 1'b0, rnd);
            check("wrap.count", 32'(count), 8);
        end

        // Mid-operation reset at count 9, including X inputs while in reset
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h42);
        check("pre_rst.count", 32'(count), 9);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h33);
        check("midrst.count", 32'(count), 0);
        check("midrst.empty", empty, 1'b1);
        check("midrst.dv",    data_valid, 1'b0);
        step(1'b0, 1'bx, 1'bx, 1'bx, 8'hxx);
        check("xrst.count", 32'(count), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5C);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("postrst.dout", data_out, 8'h5C);
        check("postrst.dv",   data_valid, 1'b1);

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 15) == 0),
                 WIDTH'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
